mod_reduce: RTL
===============

# mod_reduce

Parametrised sequential modular-reduction unit for the RSA datapath: computes M = {Hreg, Lreg} mod C and the quotient Q for a WIDTH-bit modulus. It uses one restoring-division step per clock.

- It generalises the fixed 8-bit modulo unit with a WIDTH parameter, a quotient output, a one-cycle done strobe and a divide-by-zero error flag.
- It sits between the multiplier (which produces the 2·WIDTH+1-bit product) and the modular-exponentiation controller.

## Interface
- WIDTH, default 8: modulus and remainder width. The dividend is 2·WIDTH+1 bits. N = 2·WIDTH+1 is the iteration count.

Ports:
- clk: input, 1 bit. Single clock; all state changes on the rising edge.
- rst: input, 1 bit. Reset is asynchronous and active-high.
- start: input, 1 bit. Request a reduction; sampled only while busy=0.
- C: input, WIDTH bits. Modulus.
- Hreg: input, WIDTH+1 bits. Upper dividend bits.
- Lreg: input, WIDTH bits. Lower dividend bits.
- busy: output, 1 bit. High while iterating.
- done: output, 1 bit. One-cycle strobe; result valid.
- err: output, 1 bit. C was zero at acceptance.
- M: output, WIDTH bits. Remainder.
- Q: output, 2·WIDTH+1 bits. Quotient.

## Operation
- States: IDLE, CALC.
- Registers:
  - dividend shift register D (N bits);
  - partial remainder R (WIDTH+1 bits);
  - quotient register Q (N bits);
  - latched modulus Cq (WIDTH bits);
  - iteration counter cnt (ceil(log2(N+1)) bits).
- Acceptance: when start=1 and busy=0 at a rising edge, C, Hreg and Lreg are latched. After that edge they may change freely.
- IDLE with start and C≠0:
  - D←{Hreg, Lreg}, R←0, Q←0, Cq←C, cnt←N, err←0;
  - go to CALC.
- IDLE with start and C=0:
  - stay in IDLE;
  - M←0, Q←0, err←1, done←1 for the next cycle;
  - no busy.
- CALC step, one per edge:
  - T = {R[WIDTH-1:0], D[N-1]}, WIDTH+1 bits;
  - D shifts left by 1;
  - if T ≥ {0, Cq}: R←T−Cq and Q←{Q[N-2:0], 1};
  - otherwise: R←T and Q←{Q[N-2:0], 0};
  - cnt decrements.
- On the step where cnt reaches 0: go to IDLE, M←R[WIDTH-1:0] after the final step, done←1 for one cycle.
- Arithmetic rules: R<Cq holds after every step, so R[WIDTH] is always 0 after a step. The compare and subtract use WIDTH+1 bits and never wrap.
- M, Q and err hold their values until the next accepted start. Internal state may update during CALC, but the M and Q ports expose final values only at done.
- start while busy=0 in the done cycle is accepted. Back-to-back operations are allowed with no idle gap.
- start while busy=1 is ignored; it is neither queued nor errored.

## Timing
- Reset values:
  - busy=0, done=0, err=0;
  - M=0, Q=0;
  - state IDLE, cnt=0.
- Reset mid-operation aborts immediately and asynchronously to the reset values. No done is generated for the aborted operation.
- Start accepted at edge k with C≠0:
  - busy=1 from after edge k until after edge k+N;
  - busy=0 and done=1 during the cycle after edge k+N;
  - done=0 after edge k+N+1 unless a new start produces another done.
- Latency from the start edge to done: N+1 edges. For WIDTH=8 that is 17 steps and done in the 18th cycle.
- Zero modulus accepted at edge k: done=1 and err=1 after edge k, busy never rises, latency 1.
- done is never high while busy is high.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst mid-idle -> busy=0, done=0, err=0, M=0x00, Q=0x00000.
- Basic: Hreg=0x011, Lreg=0x11, C=0xAA, start for one cycle -> busy for 17 cycles, then done with M=0x77, Q=0x00019, err=0.
- Exact multiple: dividend 0xFFFF, C=0xFF -> M=0x00, Q=0x00101.
- Maximum dividend:
  - Hreg=0x1FF, Lreg=0xFF, C=0xFF -> M=0x01, Q=0x00202;
  - same dividend with C=0x01 -> M=0x00, Q=0x1FFFF.
- Zero modulus: C=0x00 -> done and err one cycle after start, busy stays 0, M=0x00, Q=0x00000. The next valid start clears err.
- Handshake and abort:
  - start held high through an operation, with inputs changed mid-CALC -> the result matches the inputs latched at acceptance, and a second operation starts in the done cycle;
  - rst pulsed at step 5 -> outputs return to the reset values and no done is produced.

Source files
------------

// File: rtl/mod_reduce.sv
`default_nettype none
// ============================================================================
// mod_reduce : sequential {Hreg,Lreg} mod C with quotient, one restoring step
//              per clock, done strobe and zero-modulus error flag.
// Revision   : 1.0
// ============================================================================
module mod_reduce #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   C,
   input  logic [WIDTH:0]     Hreg,
   input  logic [WIDTH-1:0]   Lreg,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [WIDTH-1:0]   M,
   output logic [2*WIDTH:0]   Q
);

   localparam int c_n     = 2*WIDTH + 1;
   localparam int c_cnt_w = $clog2(c_n + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(c_n);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t             r_state;
   logic [c_n-1:0]     r_d;
   logic [WIDTH-1:0]   r_r;
   logic [WIDTH-1:0]   r_cq;
   logic [c_cnt_w-1:0] r_cnt;

   logic [WIDTH:0]     w_t;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_rem;
   logic [c_n-1:0]     w_d_next;

   // The remainder stays below Cq after every step, so its top bit is always
   // zero and only WIDTH bits are kept; for the same reason the WIDTH-bit
   // difference is exact whenever T >= Cq.
   always_comb begin
      w_t      = {r_r, r_d[c_n-1]};
      w_ge     = (w_t >= {1'b0, r_cq});
      w_diff   = w_t[WIDTH-1:0] - r_cq;
      w_rem    = w_ge ? w_diff : w_t[WIDTH-1:0];
      // Quotient bits fill the dividend bits vacated by the shift.
      w_d_next = {r_d[c_n-2:0], w_ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_d     <= '0;
         r_r     <= '0;
         r_cq    <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         M       <= '0;
         Q       <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (C != '0) begin
                     r_d     <= {Hreg, Lreg};
                     r_r     <= '0;
                     r_cq    <= C;
                     r_cnt   <= c_cnt_init;
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     r_state <= CALC;
                  end else begin
                     M    <= '0;
                     Q    <= '0;
                     err  <= 1'b1;
                     done <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_d   <= w_d_next;
               r_r   <= w_rem;
               r_cnt <= r_cnt - c_cnt_one;
               if (r_cnt == c_cnt_one) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  M       <= w_rem;
                  Q       <= w_d_next;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
